// File: rtl/zjh_dec_pkg.sv
// Shared constants and decode helpers for the scan decoder family.
// The optional anti-ghosting feature is selected with ZJH_SCAN_DEC_BLANK_EN.
package zjh_dec_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Helpers work on a fixed wide vector; callers slice down to their own width.
    localparam int MAX_AW = 8;
    localparam int MAX_N  = 2 ** MAX_AW;

    function automatic logic en_of(input logic [2:0] e);
        return e[2] & ~e[1] & ~e[0];
    endfunction

    function automatic logic [MAX_N-1:0] dec_n(input logic [MAX_AW-1:0] idx);
        logic [MAX_N-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/zjh_dwell_timer.sv
// Dwell counter for the scan decoder: counts held cycles and raises adv
// once the programmed dwell has been reached (>= so a shrunk dwell never locks up).
module zjh_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell,
    output logic               adv
);

    logic [DWELL_W-1:0] cnt_q;

    assign adv = (cnt_q >= dwell);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (step) begin
            cnt_q <= adv ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/zjh_scan_decoder.sv
// Registered N-to-2^N active-low decoder with 74HC138-style enables and auto-scan.
// Define ZJH_SCAN_DEC_BLANK_EN to insert one all-ones blank cycle on every channel change.
module zjh_scan_decoder
    import zjh_dec_pkg::*;
#(
    parameter int AW      = 3,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         e,
    input  logic               mode,
    input  logic [AW-1:0]      addr,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**AW-1:0]   y,
    output logic [AW-1:0]      cur_sel,
    output logic               wrap
);

    localparam int N = 2 ** AW;

    function automatic logic [N-1:0] dec_local(input logic [AW-1:0] i);
        logic [MAX_N-1:0] full;
        full = dec_n(MAX_AW'(i));
        return full[N-1:0];
    endfunction

    logic          en;
    logic          scan_run;
    logic          adv;
    logic          step;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_next;
    logic          mode_q;
    logic [N-1:0]  y_next;
    logic [AW-1:0] cur_sel_next;
    logic          wrap_next;
`ifdef ZJH_SCAN_DEC_BLANK_EN
    logic          blank_q;
    logic          blank_next;
    logic          drv_q;
    logic          drv_next;
`endif

    assign en       = en_of(e);
    assign scan_run = (mode == MODE_SCAN) && (mode_q == MODE_SCAN);

`ifdef ZJH_SCAN_DEC_BLANK_EN
    // The counter sits at zero through the blank so the new channel gets its full dwell.
    assign step = scan_run & en & ~blank_q;
`else
    assign step = scan_run & en;
`endif

    zjh_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~scan_run),
        .step  (step),
        .dwell (dwell),
        .adv   (adv)
    );

    always_comb begin
        idx_next     = idx_q;
        y_next       = '1;
        cur_sel_next = cur_sel;
        wrap_next    = 1'b0;
`ifdef ZJH_SCAN_DEC_BLANK_EN
        blank_next   = 1'b0;
        drv_next     = (mode == MODE_DIRECT) && en;
`endif
        if (mode == MODE_DIRECT) begin
            idx_next = '0;
            if (en) begin
                cur_sel_next = addr;
`ifdef ZJH_SCAN_DEC_BLANK_EN
                if (drv_q && !blank_q && (addr != cur_sel)) begin
                    blank_next = 1'b1;
                end else begin
                    y_next = dec_local(addr);
                end
`else
                y_next = dec_local(addr);
`endif
            end
        end else if (mode_q == MODE_DIRECT) begin
            // Entering scan: start from channel 0 immediately.
            idx_next = '0;
            if (en) begin
                y_next       = dec_local('0);
                cur_sel_next = '0;
            end
        end else if (en) begin
`ifdef ZJH_SCAN_DEC_BLANK_EN
            if (blank_q) begin
                y_next = dec_local(idx_q);
            end else if (adv) begin
                idx_next     = idx_q + 1'b1;
                cur_sel_next = idx_q + 1'b1;
                wrap_next    = &idx_q;
                blank_next   = 1'b1;
            end else begin
                y_next       = dec_local(idx_q);
                cur_sel_next = idx_q;
            end
`else
            if (adv) begin
                idx_next  = idx_q + 1'b1;
                wrap_next = &idx_q;
            end
            y_next       = dec_local(idx_next);
            cur_sel_next = idx_next;
`endif
        end else begin
`ifdef ZJH_SCAN_DEC_BLANK_EN
            // A pending blank survives a disabled stretch.
            blank_next = blank_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            mode_q  <= MODE_DIRECT;
            y       <= '1;
            cur_sel <= '0;
            wrap    <= 1'b0;
`ifdef ZJH_SCAN_DEC_BLANK_EN
            blank_q <= 1'b0;
            drv_q   <= 1'b0;
`endif
        end else begin
            idx_q   <= idx_next;
            mode_q  <= mode;
            y       <= y_next;
            cur_sel <= cur_sel_next;
            wrap    <= wrap_next;
`ifdef ZJH_SCAN_DEC_BLANK_EN
            blank_q <= blank_next;
            drv_q   <= drv_next;
`endif
        end
    end

endmodule

// File: tb/tb_zjh_scan_decoder.sv
// Directed bench for zjh_scan_decoder (AW=3); blank-cycle vectors run when
// ZJH_SCAN_DEC_BLANK_EN is defined, the default-build vectors otherwise.
module tb_zjh_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  e;
    logic        mode;
    logic [2:0]  addr;
    logic [15:0] dwell;
    logic [7:0]  y;
    logic [2:0]  cur_sel;
    logic        wrap;

    int errors = 0;
    int checks = 0;

    zjh_scan_decoder #(
        .AW      (3),
        .DWELL_W (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .e       (e),
        .mode    (mode),
        .addr    (addr),
        .dwell   (dwell),
        .y       (y),
        .cur_sel (cur_sel),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("  ok %s = %0h", tag, obs);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] onehot_n(input int ch);
        logic [7:0] v;
        v = 8'hFF;
        v[ch] = 1'b0;
        return v;
    endfunction

    task automatic restart_scan(input logic [15:0] d);
        mode = 1'b0; e = 3'b101;
        tick();
        mode = 1'b1; e = 3'b100; dwell = d;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; e = 3'b000; mode = 1'b0; addr = 3'd0; dwell = 16'd0;
        tick(); tick();
        check("reset_y", 32'(y), 32'hFF);
        check("reset_sel", 32'(cur_sel), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_release_y", 32'(y), 32'hFF);

`ifndef ZJH_SCAN_DEC_BLANK_EN
        // Direct decode and disable
        e = 3'b100; addr = 3'd5;
        tick();
        check("direct5_y", 32'(y), 32'hDF);
        check("direct5_sel", 32'(cur_sel), 32'd5);
        e = 3'b101;
        tick();
        check("disabled_y", 32'(y), 32'hFF);
        check("disabled_sel_hold", 32'(cur_sel), 32'd5);
        e = 3'b100; addr = 3'd0;
        tick();
        check("direct0_y", 32'(y), 32'hFE);

        // Scan dwell=2: three cycles per channel, wrap on the 24th following edge
        restart_scan(16'd2);
        for (int k = 0; k < 26; k++) begin
            if (k > 0) tick();
            check($sformatf("scan_d2_y[%0d]", k), 32'(y), 32'(onehot_n((k / 3) % 8)));
            check($sformatf("scan_d2_wrap[%0d]", k), 32'(wrap), (k == 24) ? 32'd1 : 32'd0);
        end
        check("scan_d2_sel", 32'(cur_sel), 32'd0);

        // Scan dwell=0: new channel every cycle
        restart_scan(16'd0);
        for (int k = 0; k < 17; k++) begin
            if (k > 0) tick();
            check($sformatf("scan_d0_y[%0d]", k), 32'(y), 32'(onehot_n(k % 8)));
            check($sformatf("scan_d0_wrap[%0d]", k), 32'(wrap), (k == 8 || k == 16) ? 32'd1 : 32'd0);
        end

        // Dwell shrink from 10 to 1 with cnt=5
        restart_scan(16'd10);
        for (int k = 0; k < 5; k++) tick();
        check("shrink_before_y", 32'(y), 32'hFE);
        dwell = 16'd1;
        tick();
        check("shrink_after_y", 32'(y), 32'hFD);
        check("shrink_after_sel", 32'(cur_sel), 32'd1);

        // Pause at idx=3, cnt=1
        restart_scan(16'd2);
        for (int k = 0; k < 10; k++) tick();
        check("pause_pre_y", 32'(y), 32'hF7);
        e = 3'b000;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("pause_y[%0d]", k), 32'(y), 32'hFF);
            check($sformatf("pause_sel[%0d]", k), 32'(cur_sel), 32'd3);
        end
        e = 3'b100;
        tick();
        check("resume_y", 32'(y), 32'hF7);
        tick();
        check("resume_adv_y", 32'(y), 32'hEF);
        check("resume_adv_sel", 32'(cur_sel), 32'd4);

        // Run on to idx=6, then asynchronous reset between edges
        for (int k = 0; k < 6; k++) tick();
        check("pre_rst_y", 32'(y), 32'hBF);
        rst_n = 1'b0;
        #2;
        check("async_rst_y", 32'(y), 32'hFF);
        check("async_rst_sel", 32'(cur_sel), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_restart_y", 32'(y), 32'hFE);
        check("rst_restart_sel", 32'(cur_sel), 32'd0);
        tick();
        check("rst_restart_hold_y", 32'(y), 32'hFE);
`else
        // Blank-cycle scan with dwell=1
        restart_scan(16'd1);
        begin
            logic [7:0] exp_seq [0:6];
            exp_seq = '{8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFF, 8'hFB};
            for (int k = 0; k < 7; k++) begin
                if (k > 0) tick();
                check($sformatf("blank_scan_y[%0d]", k), 32'(y), 32'(exp_seq[k]));
            end
        end
        check("blank_scan_sel", 32'(cur_sel), 32'd2);
        // Direct addr change 2 -> 4
        mode = 1'b0; e = 3'b100; addr = 3'd2;
        tick();
        check("blank_dir_y0", 32'(y), 32'hFB);
        addr = 3'd4;
        tick();
        check("blank_dir_y1", 32'(y), 32'hFF);
        check("blank_dir_sel1", 32'(cur_sel), 32'd4);
        tick();
        check("blank_dir_y2", 32'(y), 32'hEF);
        check("blank_dir_wrap", 32'(wrap), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zjh_scan_decoder.md
# zjh_scan_decoder

Parametrised, registered N-to-2^N line decoder with 74HC138-style three-pin enable and active-low outputs. It adds an auto-scan mode: an internal channel index steps through every output, holding each one for a programmable dwell time. It drives digit-select lines of multiplexed LED/7-segment displays and row strobes in the board-level designs, replacing the purely combinational 3-to-8 decoder.

## Interface

Parameters:
- AW, default 3: address width; output count N = 2**AW (derived, not overridable).
- DWELL_W, default 16: width of dwell programming and dwell counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- e  input  3  enable pins: e[2] active high, e[1] and e[0] active low.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- addr  input  AW  channel select in direct mode.
- dwell  input  DWELL_W  scan hold count; each channel is held dwell+1 cycles.
- y  output  N  decoded outputs, active low, registered.
- cur_sel  output  AW  index of the channel currently driven (registered).
- wrap  output  1  one-cycle pulse on the index transition N-1 -> 0 in scan mode.

## Operation

- en = e[2] & ~e[1] & ~e[0], sampled each clock.
- Direct mode:
  - On each edge with en=1, y takes all ones except y[addr]=0, and cur_sel takes addr.
  - With en=0, y takes all ones and cur_sel holds.
- Scan mode state:
  - idx, AW bits.
  - cnt, DWELL_W bits.
  - mode_q, the registered mode.
- Scan mode stepping, on each edge with en=1:
  - If cnt >= dwell: cnt <= 0 and idx <= idx+1, wrapping N-1 -> 0. wrap=1 on the wrapping edge only.
  - Otherwise cnt <= cnt+1.
- Scan mode outputs: y[idx]=0 and all other bits are 1. cur_sel = idx. Both are registered alongside idx, so the outputs match the new idx after the edge.
- Using >= means a dwell reduced mid-count advances on the next edge; there is no lockup.
- dwell=0: advance every cycle.
- Scan mode with en=0: idx and cnt hold, y goes all ones, wrap=0. Re-enabling resumes the same channel with the remaining dwell.
- Mode transitions:
  - Direct -> scan (mode=1 while mode_q=0): idx <= 0, cnt <= 0. Channel 0 is driven on that edge when en=1.
  - Scan -> direct: idx and cnt are cleared; direct decode applies on the same edge.
- wrap is 0 in direct mode.

## Timing

- Reset values:
  - y = all ones.
  - cur_sel = 0.
  - wrap = 0.
  - idx = 0, cnt = 0, mode_q = 0.
- Reset is asynchronous assert and synchronous release. On release there is no output activity until the first enabled edge.
- Direct mode latency: one cycle from e/addr to y.
- Scan mode period per channel: dwell+1 cycles. Full frame: N*(dwell+1) cycles.
- Reset asserted mid-scan: immediate return to reset values. After release, scanning restarts at channel 0.
- y is glitch-free: every bit comes from a flop, with no combinational path from inputs to y.

## Configuration

- ZJH_SCAN_DEC_BLANK_EN: anti-ghosting blank cycle.
  - Defined, scan mode: each channel advance inserts exactly one cycle of y = all ones; the new channel is driven on the following edge. The dwell count restarts after the blank, so the period becomes dwell+2.
  - Defined, direct mode: any addr change while en=1 produces one blank cycle before the new decode.
  - During the blank cycle, cur_sel already shows the new index and wrap fires with the blank cycle.
  - Undefined: no blank cycles; behaviour is exactly as in Operation.

## Structure

- Package zjh_dec_pkg holds:
  - the mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1;
  - the enable-decode function en_of(e);
  - the one-hot active-low decode function dec_n(idx).
- Sub-module zjh_dwell_timer contains cnt, the >= compare, and the advance strobe output. The top level owns idx, mode_q, y, cur_sel, wrap and the blank logic.

## Test plan

Bench runs with AW=3 and the macro undefined unless stated.

- Reset, then direct mode with e=3'b100, addr=5 -> y=8'hDF one cycle later, cur_sel=5. Then e=3'b101 -> y=8'hFF next cycle.
- Scan mode with dwell=2 and en=1 -> y sequence FE,FE,FE,FD,FD,FD,FB,...,7F then FE. wrap=1 exactly on the 7F->FE edge. The full frame is 24 cycles.
- Scan mode with dwell=0 -> y changes every cycle, wrap every 8 cycles. Changing dwell from 10 to 1 while cnt=5 -> advance on the next edge.
- Scan at idx=3 with cnt=1, then e=3'b000 for 4 cycles -> y=FF, idx held. Re-enable -> y=F7 for the remaining dwell cycles, then F7 -> EF.
- Assert rst_n low mid-scan at idx=6 -> y=FF immediately, without waiting for a clock edge. After release with scan enabled -> channel 0 (y=FE) on the first enabled edge.
- Macro defined, dwell=1 -> y sequence FE,FE,FF,FD,FD,FF,FB,... In direct mode, addr changing 2 -> 4 -> y FB, FF, EF.
